// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one external combinational ALU between two requesters and returns tagged results.
// Ports: clk/rst_n (async active-low); r0_*/r1_* valid-ready requests (a, b, op, sltiu);
// alu_* drive the external ALU and read back alu_c/alu_zero/alu_less;
// rsp_* valid-ready response carrying id, result, zero, less and err (op 11).
// Optional build macro ALU_SHARE_FIXED_PRI_EN: requester 0 always wins ties (no round-robin pointer).
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [1:0]       r0_op,
  input  logic             r0_sltiu,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [1:0]       r1_op,
  input  logic             r1_sltiu,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_sltiu,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero,
  input  logic             alu_less,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_less,
  output logic             rsp_err
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic       idle, grant1, accept;
  assign idle = state == IDLE;
`ifdef ALU_SHARE_FIXED_PRI_EN
  assign grant1 = r1_valid & ~r0_valid;
`else
  logic ptr;
  // ptr names the requester preferred on a tie; it flips away from whoever was just served
  assign grant1 = r1_valid & (~r0_valid | ptr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (accept) ptr <= ~grant1;
`endif
  assign accept    = idle & (r0_valid | r1_valid);
  // readies are gated by rst_n so nothing looks accepted while reset is held
  assign r0_ready  = rst_n & idle & r0_valid & ~grant1;
  assign r1_ready  = rst_n & idle & grant1;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= 2'b00;
      alu_sltiu  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_less   <= 1'b0;
      rsp_err    <= 1'b0;
    end else if (accept) begin
      alu_a     <= grant1 ? r1_a : r0_a;
      alu_b     <= grant1 ? r1_b : r0_b;
      alu_op    <= grant1 ? r1_op : r0_op;
      alu_sltiu <= grant1 ? r1_sltiu : r0_sltiu;
      rsp_id    <= grant1;
      state     <= EXEC;
    end else if (state == EXEC) begin
      rsp_result <= alu_op == 2'b11 ? '0 : alu_c;
      rsp_zero   <= alu_zero;
      rsp_less   <= alu_less;
      rsp_err    <= alu_op == 2'b11;
      state      <= RESP;
    end else if (!idle && rsp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: randomized self-checking bench for alu_share_arbiter with an external ALU stand-in.
module tb_alu_share_arbiter;
  localparam int W = 32;
`ifdef ALU_SHARE_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  typedef struct packed {
    logic         v;
    logic         id;
    logic [W-1:0] res;
    logic         z;
    logic         l;
    logic         e;
  } rsp_t;
  logic clk = 0, rst_n = 0;
  logic r0_valid, r0_ready, r0_sltiu, r1_valid, r1_ready, r1_sltiu;
  logic [W-1:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_c, rsp_result;
  logic [1:0] r0_op, r1_op, alu_op;
  logic alu_sltiu, alu_zero, alu_less, rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_less, rsp_err;
  int errors = 0, checks = 0;
  logic model_ptr = 1'b0;
  always #5 clk = ~clk;
  assign alu_c = alu_op == 2'd0 ? alu_a + alu_b : alu_op == 2'd1 ? alu_a - alu_b :
                 alu_op == 2'd2 ? alu_a | alu_b : alu_a ^ alu_b;
  assign alu_zero = alu_a == alu_b;
  assign alu_less = alu_sltiu ? alu_a < alu_b : $signed(alu_a) < $signed(alu_b);
  alu_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op), .r0_sltiu(r0_sltiu),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op), .r1_sltiu(r1_sltiu),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sltiu(alu_sltiu),
    .alu_c(alu_c), .alu_zero(alu_zero), .alu_less(alu_less),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_less(rsp_less), .rsp_err(rsp_err)
  );
  function automatic rsp_t expect_rsp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [1:0] op, input logic s);
    rsp_t r;
    r.v = 1'b1;
    r.id = id;
    case (op)
      2'd0: r.res = a + b;
      2'd1: r.res = a - b;
      2'd2: r.res = a | b;
      default: r.res = '0;
    endcase
    r.z = a == b;
    r.l = s ? (a < b) : ($signed(a) < $signed(b));
    r.e = op == 2'd3;
    return r;
  endfunction
  function automatic logic winner(input logic v0, input logic v1);
    return (v0 && v1) ? (FIXED ? 1'b0 : model_ptr) : v1;
  endfunction
  function automatic rsp_t sample_rsp();
    return '{rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_less, rsp_err};
  endfunction
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle_inputs;
    r0_valid = 0; r1_valid = 0; rsp_ready = 0;
    r0_a = '0; r0_b = '0; r0_op = 0; r0_sltiu = 0;
    r1_a = '0; r1_b = '0; r1_op = 0; r1_sltiu = 0;
  endtask
  task automatic set_req(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic s);
    if (id) begin r1_valid = 1; r1_a = a; r1_b = b; r1_op = op; r1_sltiu = s; end
    else begin r0_valid = 1; r0_a = a; r0_b = b; r0_op = op; r0_sltiu = s; end
  endtask
  task automatic do_reset;
    idle_inputs;
    rst_n = 0;
    step;
    rst_n = 1;
    model_ptr = 0;
  endtask
  task automatic run_one(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic s,
                         output logic rdy, output logic [W+2:0] ex, output rsp_t r, output logic after);
    idle_inputs;
    set_req(id, a, b, op, s);
    rsp_ready = 1;
    #1;
    rdy = id ? r1_ready : r0_ready;
    if (rdy) model_ptr = ~id;
    step;
    r0_valid = 0; r1_valid = 0;
    #1;
    ex = {alu_a, alu_op, alu_sltiu};
    step;
    #1;
    r = sample_rsp();
    step;
    #1;
    after = rsp_valid;
  endtask
  task automatic test_reset;
    idle_inputs;
    r0_valid = 1; r1_valid = 1;
    rst_n = 0;
    #1;
    checks++;
    if ({r0_ready, r1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", {r0_ready, r1_ready}); end
    checks++;
    if (sample_rsp() !== '0) begin errors++; $display("FAIL reset_rsp: got %h want 0", sample_rsp()); end
    checks++;
    if ({alu_a, alu_b, alu_op, alu_sltiu} !== '0) begin errors++; $display("FAIL reset_alu: got %h %h %b %b want 0", alu_a, alu_b, alu_op, alu_sltiu); end
    do_reset;
  endtask
  task automatic test_add;
    logic rdy, after; logic [W+2:0] ex; rsp_t r, e;
    run_one(0, 5, 7, 2'd0, 0, rdy, ex, r, after);
    e = expect_rsp(0, 5, 7, 2'd0, 0);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", rdy); end
    checks++;
    if (ex !== {32'd5, 2'd0, 1'b0}) begin errors++; $display("FAIL add_exec: got %h want %h", ex, {32'd5, 2'd0, 1'b0}); end
    checks++;
    if (r !== e || r.res !== 32'd12) begin errors++; $display("FAIL add_rsp: got %h want %h", r, e); end
    checks++;
    if (after !== 1'b0) begin errors++; $display("FAIL add_drop: rsp_valid got %b want 0", after); end
  endtask
  task automatic test_alternate;
    logic [2:0] seq, want;
    int n;
    rsp_t r, e;
    logic last;
    do_reset;
    seq = '0; n = 0; last = 0;
    want = FIXED ? 3'b000 : 3'b010;
    set_req(0, 9, 9, 2'd1, 0);
    set_req(1, 32'hF0, 32'h0F, 2'd2, 0);
    rsp_ready = 1;
    for (int i = 0; i < 9; i++) begin
      #1;
      if (r0_ready || r1_ready) begin
        checks++;
        if ({r1_ready, r0_ready} !== (winner(1, 1) ? 2'b10 : 2'b01)) begin
          errors++; $display("FAIL alt_grant%0d: got %b want winner %b", n, {r1_ready, r0_ready}, winner(1, 1));
        end
        last = r1_ready;
        if (n < 3) seq[2-n] = r1_ready;
        n++;
        model_ptr = ~r1_ready;
      end
      if (rsp_valid) begin
        r = sample_rsp();
        e = r.id ? expect_rsp(1, 32'hF0, 32'h0F, 2'd2, 0) : expect_rsp(0, 9, 9, 2'd1, 0);
        checks++;
        if (r !== e || r.id !== last) begin errors++; $display("FAIL alt_rsp: got %h want %h (grant %b)", r, e, last); end
      end
      step;
    end
    idle_inputs;
    checks++;
    if (n !== 3 || seq !== want) begin errors++; $display("FAIL alt_seq: got %0d grants %b want 3 grants %b", n, seq, want); end
  endtask
  task automatic test_illegal;
    logic rdy, after; logic [W+2:0] ex; rsp_t r, e;
    run_one(1, 3, 4, 2'd3, 0, rdy, ex, r, after);
    e = expect_rsp(1, 3, 4, 2'd3, 0);
    checks++;
    if (rdy !== 1'b1 || r !== e || r.e !== 1'b1 || r.res !== '0) begin
      errors++; $display("FAIL illegal: ready %b got %h want %h", rdy, r, e);
    end
  endtask
  task automatic test_sltiu;
    logic rdy, after; logic [W+2:0] ex; rsp_t r;
    for (int s = 0; s < 2; s++) begin
      run_one(0, 32'hFFFF_FFFF, 1, 2'd1, s[0], rdy, ex, r, after);
      checks++;
      if (r.l !== ~s[0] || r !== expect_rsp(0, 32'hFFFF_FFFF, 1, 2'd1, s[0])) begin
        errors++; $display("FAIL sltiu%0d: less got %b want %b", s, r.l, ~s[0]);
      end
    end
  endtask
  task automatic test_hold;
    rsp_t snap, e;
    logic [W-1:0] a, b;
    a = $urandom; b = $urandom;
    idle_inputs;
    set_req(1, a, b, 2'd0, 0);
    #1;
    if (r1_ready) model_ptr = 0;
    step;
    r1_valid = 0;
    step;
    #1;
    snap = sample_rsp();
    e = expect_rsp(1, a, b, 2'd0, 0);
    checks++;
    if (snap !== e) begin errors++; $display("FAIL hold_first: got %h want %h", snap, e); end
    set_req(0, 20, 22, 2'd0, 1);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (sample_rsp() !== snap || r0_ready !== 1'b0) begin
        errors++; $display("FAIL hold_stable%0d: got %h ready %b want %h ready 0", i, sample_rsp(), r0_ready, snap);
      end
      step;
    end
    rsp_ready = 1;
    #1;
    checks++;
    if (r0_ready !== 1'b0) begin errors++; $display("FAIL hold_hs_ready: got %b want 0", r0_ready); end
    step;
    #1;
    checks++;
    if (r0_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL hold_next_accept: ready %b valid %b want 1 0", r0_ready, rsp_valid);
    end
    model_ptr = 1;
    step;
    r0_valid = 0;
    step;
    #1;
    e = expect_rsp(0, 20, 22, 2'd0, 1);
    checks++;
    if (sample_rsp() !== e) begin errors++; $display("FAIL hold_second: got %h want %h", sample_rsp(), e); end
    step;
  endtask
  task automatic test_reset_mid;
    rsp_t e;
    idle_inputs;
    set_req(0, 1, 2, 2'd0, 0);
    step;
    set_req(1, 6, 6, 2'd1, 0);
    rst_n = 0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_op, alu_sltiu} !== '0 || sample_rsp() !== '0 || {r0_ready, r1_ready} !== 2'b00) begin
      errors++; $display("FAIL midreset_out: alu %h %h rsp %h ready %b want all 0", alu_a, alu_b, sample_rsp(), {r0_ready, r1_ready});
    end
    step;
    idle_inputs;
    rsp_ready = 1;
    rst_n = 1;
    model_ptr = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset_norsp%0d: rsp_valid got 1 want 0", i); end
      step;
    end
    set_req(0, 40, 2, 2'd1, 0);
    set_req(1, 3, 3, 2'd2, 1);
    #1;
    checks++;
    if ({r1_ready, r0_ready} !== 2'b01) begin errors++; $display("FAIL midreset_ptr: got %b want 01", {r1_ready, r0_ready}); end
    model_ptr = 1;
    step;
    r0_valid = 0; r1_valid = 0;
    step;
    #1;
    e = expect_rsp(0, 40, 2, 2'd1, 0);
    checks++;
    if (sample_rsp() !== e) begin errors++; $display("FAIL midreset_rsp: got %h want %h", sample_rsp(), e); end
    step;
  endtask
  task automatic test_random;
    logic [1:0] v;
    logic w;
    rsp_t e;
    logic [W+2:0] want_alu;
    int d;
    for (int i = 0; i < 40; i++) begin
      idle_inputs;
      v = 2'($urandom_range(1, 3));
      if (v[0]) set_req(0, $urandom, $urandom_range(0, 3) == 0 ? r0_a : $urandom, 2'($urandom), 1'($urandom));
      if (v[1]) set_req(1, $urandom, $urandom, 2'($urandom), 1'($urandom));
      if (v[0] && $urandom_range(0, 3) == 0) r0_b = r0_a;
      #1;
      w = winner(v[0], v[1]);
      e = w ? expect_rsp(1, r1_a, r1_b, r1_op, r1_sltiu) : expect_rsp(0, r0_a, r0_b, r0_op, r0_sltiu);
      want_alu = w ? {r1_a, r1_op, r1_sltiu} : {r0_a, r0_op, r0_sltiu};
      checks++;
      if ({r1_ready, r0_ready} !== (w ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rnd%0d_grant: got %b want %b (valid %b)", i, {r1_ready, r0_ready}, w ? 2'b10 : 2'b01, v);
      end
      model_ptr = ~w;
      step;
      r0_valid = 0; r1_valid = 0;
      r0_a = $urandom; r1_a = $urandom; r0_op = 2'($urandom); r1_op = 2'($urandom);
      #1;
      checks++;
      if ({alu_a, alu_op, alu_sltiu} !== want_alu) begin
        errors++; $display("FAIL rnd%0d_alu: got %h want %h", i, {alu_a, alu_op, alu_sltiu}, want_alu);
      end
      step;
      d = $urandom_range(0, 3);
      for (int k = 0; k < d; k++) begin
        #1;
        checks++;
        if (sample_rsp() !== e) begin errors++; $display("FAIL rnd%0d_wait%0d: got %h want %h", i, k, sample_rsp(), e); end
        step;
      end
      rsp_ready = 1;
      #1;
      checks++;
      if (sample_rsp() !== e) begin errors++; $display("FAIL rnd%0d_rsp: got %h want %h", i, sample_rsp(), e); end
      step;
      rsp_ready = 0;
      #1;
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd%0d_drop: rsp_valid got 1 want 0", i); end
    end
  endtask
  initial begin
    idle_inputs;
    @(negedge clk);
    test_reset;
    test_add;
    test_alternate;
    test_illegal;
    test_sltiu;
    test_hold;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single 32-bit ALU (add/sub/or, zero flag, signed/unsigned less flag) between two requesters, e.g. the main datapath and an address/compare helper.
- Arbitrates, latches the winner's operands, drives the ALU for one execute cycle and registers the result.
- Returns the result over a valid/ready response channel tagged with the requester id.
- Sits between the requesters and the ALU ports; the ALU itself stays combinational and external.

Parameters:
- WIDTH, 32, operand/result width. Must match the ALU.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- r0_valid  in  1  requester 0 has an operation
- r0_ready  out  1  requester 0 operation accepted this cycle
- r0_a, r0_b  in  WIDTH  requester 0 operands
- r0_op  in  2  requester 0 ALUOP: 00 add, 01 sub, 10 or, 11 illegal
- r0_sltiu  in  1  requester 0 unsigned-compare select
- r1_valid, r1_ready, r1_a, r1_b, r1_op, r1_sltiu  same as above, for requester 1
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_op  out  2  ALUOP to the ALU
- alu_sltiu  out  1  sltiu to the ALU
- alu_c  in  WIDTH  ALU result
- alu_zero  in  1  ALU equality flag
- alu_less  in  1  ALU less flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester that owns the response
- rsp_result  out  WIDTH  registered alu_c
- rsp_zero  out  1  registered alu_zero
- rsp_less  out  1  registered alu_less
- rsp_err  out  1  op was 11; result forced to 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE, priority pointer=0. All registered outputs are 0, including alu_a/b/op/sltiu, rsp_*, rsp_id and rsp_err. r0_ready=r1_ready=0.
- Reset mid-operation aborts the transaction. No response is produced and no ready is re-issued.

FSM states:
- IDLE
  - rX_ready is combinational and high only in IDLE, and only for the winner.
  - Winner rule: if only one valid, that one wins. If both valid, the pointer's requester wins.
  - On accept: latch a, b, op, sltiu and id; pointer <= ~granted id; go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle)
  - alu_* are driven from the latched registers.
  - At the closing edge: rsp_result <= (op==11) ? 0 : alu_c; rsp_zero <= alu_zero; rsp_less <= alu_less; rsp_err <= (op==11).
  - Go to RESP.
- RESP
  - rsp_valid=1. rsp_* and rsp_id stay stable until rsp_ready=1.
  - On handshake go to IDLE. rsp_valid drops the next cycle.

Timing and data rules:
- Latency: accept in cycle T, EXEC in T+1, rsp_valid from T+2. The next accept is earliest at T+3 (no overlap).
- alu_* outputs hold the last latched values outside EXEC.
- No arithmetic is done in this block; width is passed through unchanged.
- Requester inputs are sampled only at the accept edge. Changes after acceptance have no effect.
- A requester that drops valid before being granted is never accepted and the pointer is unchanged.
- rsp_ready while not in RESP is ignored.

Optional Feature:
- Macro: ALU_SHARE_FIXED_PRI_EN.
- Defined: requester 0 always wins when both are valid. The pointer is not implemented and requester 1 can starve.
- Undefined (default): round-robin pointer exactly as in Behaviour.

Test Plan:
- Reset then r0 add, a=5, b=7, rsp_ready=1 -> r0_ready in T. EXEC has alu_op=00. T+2: rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
- Both valid continuously with ops sub(9,9) on r0 and or(0xF0,0x0F) on r1 -> grants alternate 0,1,0. r0 response gives result=0, zero=1; r1 response gives 0xFF. With ALU_SHARE_FIXED_PRI_EN defined, r0 wins every time.
- r1 op 11 with a=3, b=4 -> rsp_err=1, rsp_result=0, rsp_id=1.
- In RESP hold rsp_ready=0 for 5 cycles while r0_valid=1 -> rsp_* stable, r0_ready stays 0. Raise rsp_ready -> r0 is accepted 1 cycle after the handshake.
- sltiu compare with a=0xFFFFFFFF, b=1: sltiu=1 -> rsp_less=0. sltiu=0 -> rsp_less=1.
- Assert rst_n=0 during EXEC -> outputs 0 immediately and state IDLE. After release no response appears; a new request is served normally with pointer=0.
